// File: rtl/udp_ts_buf_pkg.sv
// Shared definitions for the UDP timestamp tx buffer queue: FSM state
// encodings, the default pointer width and a constant-foldable clog2.
package udp_ts_buf_pkg;

    localparam int LP_POINTER_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        POP_READ = 3'd2,
        POP_ACK  = 3'd3,
        RELEASE  = 3'd4,
        DONE_ACK = 3'd5
    } queue_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 30; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/udp_ts_ptr_ram.sv
// Pointer storage: one write port, one read port with a registered read
// address (data follows the address captured at the previous edge).
// Storage contents are deliberately left unreset.
module udp_ts_ptr_ram #(
    parameter int P_DEPTH  = 4,
    parameter int P_WIDTH  = 2,
    parameter int P_ADDR_W = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [P_ADDR_W-1:0] i_wr_addr,
    input  logic [P_WIDTH-1:0]  i_wr_data,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    output logic [P_WIDTH-1:0]  o_rd_data
);

    logic [P_WIDTH-1:0]  r_mem [P_DEPTH];
    logic [P_ADDR_W-1:0] r_rd_addr;

    // Write port: store the incoming pointer at the write address.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-address register: only the address is reset, never the storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr <= {P_ADDR_W{1'b0}};
        end else begin
            r_rd_addr <= i_rd_addr;
        end
    end

    assign o_rd_data = r_mem[r_rd_addr];

endmodule

// File: rtl/udp_ts_tx_buf_queue.sv
// Queue of filled frame-buffer pointers between the Ethernet rx writer and
// the tx reader, plus the release path that returns transmitted buffers to
// the free-pointer pool. One FSM arbitrates the three request/ack handshakes.
module udp_ts_tx_buf_queue
    import udp_ts_buf_pkg::*;
#(
    parameter int P_POINTERS      = 4,
    parameter int P_POINTER_WIDTH = LP_POINTER_WIDTH
) (
    input  logic                             payload_clk,
    input  logic                             payload_rst,
    input  logic                             rx_done,
    input  logic [P_POINTER_WIDTH-1:0]       rx_done_pointer,
    output logic                             rx_done_ack,
    input  logic                             tx_fetch,
    output logic                             tx_fetch_ack,
    output logic [P_POINTER_WIDTH-1:0]       pointer_out,
    input  logic                             tx_done,
    input  logic [P_POINTER_WIDTH-1:0]       tx_done_pointer,
    output logic                             tx_done_ack,
    output logic                             tx_release,
    output logic [P_POINTER_WIDTH-1:0]       tx_release_pointer,
    input  logic                             tx_release_ack,
    output logic [clog2(P_POINTERS+1)-1:0]   queue_depth,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow_flag,
    input  logic                             clear_overflow
);

    localparam int LP_IDX_W   = (clog2(P_POINTERS) > 0) ? clog2(P_POINTERS) : 1;
    localparam int LP_DEPTH_W = clog2(P_POINTERS + 1);

    queue_state_e                r_state;
    queue_state_e                w_next_state;

    logic                        r_rx_done_ack;
    logic                        r_tx_fetch_ack;
    logic                        r_tx_done_ack;
    logic                        r_tx_release;
    logic [P_POINTER_WIDTH-1:0]  r_tx_release_pointer;
    logic [P_POINTER_WIDTH-1:0]  r_pointer_out;

    // One-cycle masks covering the IDLE cycle in which a just-acked
    // requester is still allowed to be dropping its request.
    logic                        r_rx_mask;
    logic                        r_fetch_mask;
    logic                        r_done_mask;

    logic [LP_IDX_W-1:0]         r_wr_ptr;
    logic [LP_IDX_W-1:0]         r_rd_ptr;
    logic [LP_IDX_W-1:0]         w_wr_ptr_next;
    logic [LP_IDX_W-1:0]         w_rd_ptr_next;
    logic [LP_DEPTH_W-1:0]       r_depth;
    logic [LP_DEPTH_W-1:0]       w_depth_next;
    logic                        r_empty;
    logic                        r_full;
    logic                        r_overflow;
    logic                        w_overflow_next;
    logic                        w_ram_we;
    logic [P_POINTER_WIDTH-1:0]  w_ram_rd_data;

    logic                        w_done_req;
    logic                        w_rx_req;
    logic                        w_fetch_req;

    // Circular increment that wraps at P_POINTERS (not only at powers of two).
    function automatic logic [LP_IDX_W-1:0] wrap_inc(input logic [LP_IDX_W-1:0] idx);
        logic [LP_IDX_W-1:0] result;
        if (idx == LP_IDX_W'(P_POINTERS - 1)) begin
            result = {LP_IDX_W{1'b0}};
        end else begin
            result = idx + LP_IDX_W'(1);
        end
        return result;
    endfunction

    assign w_done_req  = tx_done  & ~r_done_mask;
    assign w_rx_req    = rx_done  & ~r_rx_mask;
    assign w_fetch_req = tx_fetch & ~r_fetch_mask & ~r_empty;

    udp_ts_ptr_ram #(
        .P_DEPTH  (P_POINTERS),
        .P_WIDTH  (P_POINTER_WIDTH),
        .P_ADDR_W (LP_IDX_W)
    ) u_ptr_ram (
        .i_clk     (payload_clk),
        .i_rst     (payload_rst),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_done_pointer),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

    // State register.
    always_ff @(posedge payload_clk) begin
        if (payload_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: release beats push beats fetch; fetch waits while empty.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_done_req) begin
                    w_next_state = RELEASE;
                end else if (w_rx_req) begin
                    w_next_state = PUSH;
                end else if (w_fetch_req) begin
                    w_next_state = POP_READ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            PUSH:     w_next_state = IDLE;
            POP_READ: w_next_state = POP_ACK;
            POP_ACK:  w_next_state = IDLE;
            RELEASE: begin
                if (tx_release_ack) begin
                    w_next_state = DONE_ACK;
                end else begin
                    w_next_state = RELEASE;
                end
            end
            DONE_ACK: w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Queue bookkeeping: write/advance on PUSH (unless full), advance on POP_ACK,
    // sticky overflow with clear taking precedence.
    always_comb begin
        w_ram_we        = 1'b0;
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_depth_next    = r_depth;
        w_overflow_next = r_overflow;
        if ((r_state == PUSH) && !r_full) begin
            w_ram_we      = 1'b1;
            w_wr_ptr_next = wrap_inc(r_wr_ptr);
            w_depth_next  = r_depth + LP_DEPTH_W'(1);
        end else if ((r_state == POP_ACK) && !r_empty) begin
            w_rd_ptr_next = wrap_inc(r_rd_ptr);
            w_depth_next  = r_depth - LP_DEPTH_W'(1);
        end else begin
            w_depth_next  = r_depth;
        end
        if (clear_overflow) begin
            w_overflow_next = 1'b0;
        end else if ((r_state == PUSH) && r_full) begin
            w_overflow_next = 1'b1;
        end else begin
            w_overflow_next = r_overflow;
        end
    end

    // Queue state registers; empty/full are registered from the next depth.
    always_ff @(posedge payload_clk) begin
        if (payload_rst) begin
            r_wr_ptr   <= {LP_IDX_W{1'b0}};
            r_rd_ptr   <= {LP_IDX_W{1'b0}};
            r_depth    <= {LP_DEPTH_W{1'b0}};
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_depth    <= w_depth_next;
            r_empty    <= (w_depth_next == {LP_DEPTH_W{1'b0}});
            r_full     <= (w_depth_next == LP_DEPTH_W'(P_POINTERS));
            r_overflow <= w_overflow_next;
        end
    end

    // Handshake outputs: one-cycle acks, held release request, fetched pointer.
    always_ff @(posedge payload_clk) begin
        if (payload_rst) begin
            r_rx_done_ack        <= 1'b0;
            r_tx_fetch_ack       <= 1'b0;
            r_tx_done_ack        <= 1'b0;
            r_tx_release         <= 1'b0;
            r_tx_release_pointer <= {P_POINTER_WIDTH{1'b0}};
            r_pointer_out        <= {P_POINTER_WIDTH{1'b0}};
            r_rx_mask            <= 1'b0;
            r_fetch_mask         <= 1'b0;
            r_done_mask          <= 1'b0;
        end else begin
            r_rx_done_ack  <= (r_state == IDLE) && (w_next_state == PUSH);
            r_tx_fetch_ack <= (r_state == POP_READ);
            r_tx_done_ack  <= (r_state == RELEASE) && (w_next_state == DONE_ACK);
            if ((r_state == IDLE) && (w_next_state == RELEASE)) begin
                r_tx_release         <= 1'b1;
                r_tx_release_pointer <= tx_done_pointer;
            end else if ((r_state == RELEASE) && (w_next_state == DONE_ACK)) begin
                r_tx_release         <= 1'b0;
            end else begin
                r_tx_release         <= r_tx_release;
            end
            if (r_state == POP_READ) begin
                r_pointer_out <= w_ram_rd_data;
            end else begin
                r_pointer_out <= r_pointer_out;
            end
            r_rx_mask    <= r_rx_done_ack;
            r_fetch_mask <= r_tx_fetch_ack;
            r_done_mask  <= r_tx_done_ack;
        end
    end

    assign rx_done_ack        = r_rx_done_ack;
    assign tx_fetch_ack       = r_tx_fetch_ack;
    assign tx_done_ack        = r_tx_done_ack;
    assign tx_release         = r_tx_release;
    assign tx_release_pointer = r_tx_release_pointer;
    assign pointer_out        = r_pointer_out;
    assign queue_depth        = r_depth;
    assign empty              = r_empty;
    assign full               = r_full;
    assign overflow_flag      = r_overflow;

endmodule

// File: tb/tb_udp_ts_tx_buf_queue.sv
// Directed self-checking bench for udp_ts_tx_buf_queue (P_POINTERS=4, width 2).
module tb_udp_ts_tx_buf_queue;

    logic       payload_clk;
    logic       payload_rst;
    logic       rx_done;
    logic [1:0] rx_done_pointer;
    logic       rx_done_ack;
    logic       tx_fetch;
    logic       tx_fetch_ack;
    logic [1:0] pointer_out;
    logic       tx_done;
    logic [1:0] tx_done_pointer;
    logic       tx_done_ack;
    logic       tx_release;
    logic [1:0] tx_release_pointer;
    logic       tx_release_ack;
    logic [2:0] queue_depth;
    logic       empty;
    logic       full;
    logic       overflow_flag;
    logic       clear_overflow;

    int n_checks;
    int n_fail;

    udp_ts_tx_buf_queue #(
        .P_POINTERS      (4),
        .P_POINTER_WIDTH (2)
    ) dut (
        .payload_clk        (payload_clk),
        .payload_rst        (payload_rst),
        .rx_done            (rx_done),
        .rx_done_pointer    (rx_done_pointer),
        .rx_done_ack        (rx_done_ack),
        .tx_fetch           (tx_fetch),
        .tx_fetch_ack       (tx_fetch_ack),
        .pointer_out        (pointer_out),
        .tx_done            (tx_done),
        .tx_done_pointer    (tx_done_pointer),
        .tx_done_ack        (tx_done_ack),
        .tx_release         (tx_release),
        .tx_release_pointer (tx_release_pointer),
        .tx_release_ack     (tx_release_ack),
        .queue_depth        (queue_depth),
        .empty              (empty),
        .full               (full),
        .overflow_flag      (overflow_flag),
        .clear_overflow     (clear_overflow)
    );

    initial payload_clk = 1'b0;
    always #5 payload_clk = ~payload_clk;

    // Push one pointer; lat = edges until ack seen (-1 on timeout), ack_after = ack one cycle later.
    task automatic push_ptr(input logic [1:0] v, output int lat, output logic ack_after);
        lat = -1;
        rx_done = 1'b1;
        rx_done_pointer = v;
        for (int c = 1; c <= 30; c++) begin
            @(posedge payload_clk); #1;
            if (rx_done_ack === 1'b1) begin
                lat = c;
                break;
            end
        end
        rx_done = 1'b0;
        @(posedge payload_clk); #1;
        ack_after = rx_done_ack;
        @(posedge payload_clk); #1;
    endtask

    // Fetch one pointer; lat = edges until ack seen (-1 on timeout).
    task automatic fetch_ptr(output logic [1:0] v, output int lat, output logic ack_after);
        lat = -1;
        v = 2'd0;
        tx_fetch = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge payload_clk); #1;
            if (tx_fetch_ack === 1'b1) begin
                lat = c;
                v = pointer_out;
                break;
            end
        end
        tx_fetch = 1'b0;
        @(posedge payload_clk); #1;
        ack_after = tx_fetch_ack;
        @(posedge payload_clk); #1;
    endtask

    task automatic test_reset();
        payload_rst = 1'b1;
        repeat (2) @(posedge payload_clk);
        #1;
        n_checks++;
        if ({rx_done_ack, tx_fetch_ack, tx_done_ack, tx_release} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_acks: got %b expected 0000", {rx_done_ack, tx_fetch_ack, tx_done_ack, tx_release});
        end
        n_checks++;
        if ({pointer_out, tx_release_pointer} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pointers: got %b expected 0000", {pointer_out, tx_release_pointer});
        end
        n_checks++;
        if ({queue_depth, empty, full, overflow_flag} !== 6'b000_1_0_0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 000100", {queue_depth, empty, full, overflow_flag});
        end
        payload_rst = 1'b0;
        @(posedge payload_clk); #1;
    endtask

    task automatic test_fifo_order();
        logic [1:0] vals [3];
        logic [1:0] got;
        int lat;
        logic ack_after;
        vals[0] = 2'd2; vals[1] = 2'd0; vals[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            push_ptr(vals[i], lat, ack_after);
            n_checks++;
            if (lat !== 1 || ack_after !== 1'b0) begin
                n_fail++;
                $display("FAIL push_ack_%0d: latency %0d ack_after %b expected 1 and 0", i, lat, ack_after);
            end
        end
        n_checks++;
        if (queue_depth !== 3'd3 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL depth_after_push: depth %0d empty %b expected 3 and 0", queue_depth, empty);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_ptr(got, lat, ack_after);
            n_checks++;
            if (got !== vals[i] || lat !== 2 || ack_after !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_order_%0d: ptr %0d lat %0d ack_after %b expected ptr %0d lat 2 ack_after 0",
                         i, got, lat, ack_after, vals[i]);
            end
            n_checks++;
            if (queue_depth !== 3'(2 - i)) begin
                n_fail++;
                $display("FAIL depth_after_fetch_%0d: got %0d expected %0d", i, queue_depth, 2 - i);
            end
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_after_drain: got %b expected 1", empty);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] vals [4];
        logic [1:0] got;
        int lat;
        logic ack_after;
        vals[0] = 2'd3; vals[1] = 2'd0; vals[2] = 2'd2; vals[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            push_ptr(vals[i], lat, ack_after);
        end
        n_checks++;
        if (full !== 1'b1 || queue_depth !== 3'd4 || overflow_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_4: full %b depth %0d ovf %b expected 1 4 0", full, queue_depth, overflow_flag);
        end
        push_ptr(2'd1, lat, ack_after);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL overflow_ack: latency %0d expected 1", lat);
        end
        n_checks++;
        if (overflow_flag !== 1'b1 || queue_depth !== 3'd4 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_state: ovf %b depth %0d full %b expected 1 4 1", overflow_flag, queue_depth, full);
        end
        clear_overflow = 1'b1;
        @(posedge payload_clk); #1;
        clear_overflow = 1'b0;
        n_checks++;
        if (overflow_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_overflow: got %b expected 0", overflow_flag);
        end
        for (int i = 0; i < 4; i++) begin
            fetch_ptr(got, lat, ack_after);
            n_checks++;
            if (got !== vals[i] || lat !== 2) begin
                n_fail++;
                $display("FAIL overflow_drain_%0d: ptr %0d lat %0d expected ptr %0d lat 2", i, got, lat, vals[i]);
            end
        end
    endtask

    task automatic test_fetch_empty();
        int bad_ack;
        int bad_hold;
        logic got_rx;
        logic got_fetch;
        logic [1:0] fetched;
        bad_ack = 0;
        bad_hold = 0;
        got_rx = 1'b0;
        got_fetch = 1'b0;
        fetched = 2'd0;
        tx_fetch = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge payload_clk); #1;
            if (tx_fetch_ack !== 1'b0) bad_ack++;
            if (pointer_out !== 2'd1) bad_hold++;
        end
        n_checks++;
        if (bad_ack != 0) begin
            n_fail++;
            $display("FAIL fetch_while_empty: %0d ack cycles expected 0", bad_ack);
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("FAIL pointer_out_hold: %0d cycles not 1 expected 0", bad_hold);
        end
        rx_done = 1'b1;
        rx_done_pointer = 2'd2;
        for (int c = 0; c < 40; c++) begin
            @(posedge payload_clk); #1;
            if (rx_done_ack === 1'b1) begin
                got_rx = 1'b1;
                rx_done = 1'b0;
            end
            if (tx_fetch_ack === 1'b1) begin
                got_fetch = 1'b1;
                fetched = pointer_out;
                break;
            end
        end
        tx_fetch = 1'b0;
        rx_done = 1'b0;
        repeat (2) @(posedge payload_clk);
        #1;
        n_checks++;
        if (got_rx !== 1'b1 || got_fetch !== 1'b1 || fetched !== 2'd2) begin
            n_fail++;
            $display("FAIL fetch_after_push: rx_ack %b fetch_ack %b ptr %0d expected 1 1 2", got_rx, got_fetch, fetched);
        end
        n_checks++;
        if (queue_depth !== 3'd0) begin
            n_fail++;
            $display("FAIL depth_after_wait_fetch: got %0d expected 0", queue_depth);
        end
    endtask

    task automatic test_release();
        int hold_bad;
        hold_bad = 0;
        tx_done = 1'b1;
        tx_done_pointer = 2'd3;
        tx_release_ack = 1'b0;
        @(posedge payload_clk); #1;
        n_checks++;
        if (tx_release !== 1'b1 || tx_release_pointer !== 2'd3) begin
            n_fail++;
            $display("FAIL release_start: rel %b ptr %0d expected 1 3", tx_release, tx_release_pointer);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge payload_clk); #1;
            if (tx_release !== 1'b1 || tx_release_pointer !== 2'd3 || tx_done_ack !== 1'b0) hold_bad++;
        end
        n_checks++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("FAIL release_hold: %0d bad cycles expected 0", hold_bad);
        end
        tx_release_ack = 1'b1;
        @(posedge payload_clk); #1;
        tx_release_ack = 1'b0;
        n_checks++;
        if (tx_done_ack !== 1'b1 || tx_release !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ack_pulse: done_ack %b rel %b expected 1 0", tx_done_ack, tx_release);
        end
        tx_done = 1'b0;
        @(posedge payload_clk); #1;
        n_checks++;
        if (tx_done_ack !== 1'b0 || tx_release !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ack_one_cycle: done_ack %b rel %b expected 0 0", tx_done_ack, tx_release);
        end
        @(posedge payload_clk); #1;
    endtask

    task automatic test_priority();
        int order [3];
        int n_ev;
        logic [1:0] fetched;
        n_ev = 0;
        fetched = 2'd0;
        for (int i = 0; i < 3; i++) order[i] = 0;
        rx_done = 1'b1;
        rx_done_pointer = 2'd1;
        tx_done = 1'b1;
        tx_done_pointer = 2'd2;
        tx_fetch = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge payload_clk); #1;
            if (tx_release_ack === 1'b1) tx_release_ack = 1'b0;
            else if (tx_release === 1'b1) tx_release_ack = 1'b1;
            if (tx_done_ack === 1'b1 && n_ev < 3) begin
                order[n_ev] = 1; n_ev++; tx_done = 1'b0;
            end
            if (rx_done_ack === 1'b1 && n_ev < 3) begin
                order[n_ev] = 2; n_ev++; rx_done = 1'b0;
            end
            if (tx_fetch_ack === 1'b1 && n_ev < 3) begin
                order[n_ev] = 3; n_ev++; fetched = pointer_out; tx_fetch = 1'b0;
            end
            if (n_ev >= 3) break;
        end
        rx_done = 1'b0;
        tx_done = 1'b0;
        tx_fetch = 1'b0;
        tx_release_ack = 1'b0;
        repeat (2) @(posedge payload_clk);
        #1;
        n_checks++;
        if (n_ev != 3 || order[0] != 1 || order[1] != 2 || order[2] != 3) begin
            n_fail++;
            $display("FAIL priority_order: events %0d order %0d%0d%0d expected 3 events order 123",
                     n_ev, order[0], order[1], order[2]);
        end
        n_checks++;
        if (fetched !== 2'd1 || tx_release_pointer !== 2'd2) begin
            n_fail++;
            $display("FAIL priority_data: fetched %0d rel_ptr %0d expected 1 2", fetched, tx_release_pointer);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [1:0] v;
        logic [1:0] got;
        int lat;
        logic ack_after;
        logic seen_rel;
        seen_rel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v = 2'((i + 3) % 4);
            push_ptr(v, lat, ack_after);
            fetch_ptr(got, lat, ack_after);
            n_checks++;
            if (got !== v || lat !== 2) begin
                n_fail++;
                $display("FAIL wrap_%0d: ptr %0d lat %0d expected ptr %0d lat 2", i, got, lat, v);
            end
        end
        push_ptr(2'd2, lat, ack_after);
        tx_done = 1'b1;
        tx_done_pointer = 2'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge payload_clk); #1;
            if (tx_release === 1'b1) begin
                seen_rel = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen_rel !== 1'b1 || queue_depth !== 3'd1 || pointer_out !== 2'd3) begin
            n_fail++;
            $display("FAIL pre_reset_state: rel %b depth %0d ptr_out %0d expected 1 1 3", seen_rel, queue_depth, pointer_out);
        end
        payload_rst = 1'b1;
        tx_done = 1'b0;
        @(posedge payload_clk); #1;
        n_checks++;
        if ({tx_release, tx_release_pointer, pointer_out, rx_done_ack, tx_fetch_ack, tx_done_ack} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_in_release_outputs: got %b expected 00000000",
                     {tx_release, tx_release_pointer, pointer_out, rx_done_ack, tx_fetch_ack, tx_done_ack});
        end
        n_checks++;
        if ({queue_depth, empty, full, overflow_flag} !== 6'b000_1_0_0) begin
            n_fail++;
            $display("FAIL reset_in_release_status: got %b expected 000100", {queue_depth, empty, full, overflow_flag});
        end
        payload_rst = 1'b0;
        repeat (2) @(posedge payload_clk);
        #1;
        n_checks++;
        if (tx_release !== 1'b0 || tx_done_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: rel %b done_ack %b expected 0 0", tx_release, tx_done_ack);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        payload_rst = 1'b1;
        rx_done = 1'b0;
        rx_done_pointer = 2'd0;
        tx_fetch = 1'b0;
        tx_done = 1'b0;
        tx_done_pointer = 2'd0;
        tx_release_ack = 1'b0;
        clear_overflow = 1'b0;
        test_reset();
        test_fifo_order();
        test_overflow();
        test_fetch_empty();
        test_release();
        test_priority();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
